// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel counts fastclk cycles up to its effective half-period and
// flips a registered square wave, pulsing a one-cycle strobe on every flip.
// Half-periods are runtime-loadable; a write or a sync_restart realigns phase.
module prog_clk_divider #(
  parameter int                NUM_CH       = 3,
  parameter int                CNT_W        = 32,
  parameter logic [CNT_W-1:0]  DEFAULT_HALF = CNT_W'(25000000)
) (
  input  logic                    fastclk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic                    sync_restart,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       slowclk,
  output logic [NUM_CH-1:0]       toggle_stb,
  output logic [NUM_CH*CNT_W-1:0] half_rd
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] half_q [NUM_CH];
  logic [CNT_W-1:0] half_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] slow_q, slow_d;
  logic [NUM_CH-1:0] stb_q,  stb_d;
  logic [NUM_CH-1:0] wr_sel;

  // Decode the config write into a one-hot channel select; out-of-range
  // channel indices select nothing, so the write is silently dropped.
  always_comb begin
    wr_sel = '0;
    if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == 3'(i)) wr_sel[i] = 1'b1;
      end
    end
  end

  // Per-channel next state: write/restart clear the phase, otherwise an
  // enabled channel counts to eh-1 and toggles; a disabled one holds.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic [CNT_W-1:0] term;
      // Terminal count is eh-1; a zero half behaves as one (term = 0).
      term      = (half_q[i] == CNT_ZERO) ? CNT_ZERO : (half_q[i] - CNT_ONE);
      half_d[i] = wr_sel[i] ? cfg_half : half_q[i];
      cnt_d[i]  = cnt_q[i];
      slow_d[i] = slow_q[i];
      stb_d[i]  = 1'b0;
      if (sync_restart || wr_sel[i]) begin
        cnt_d[i]  = CNT_ZERO;
        slow_d[i] = 1'b0;
      end else if (ch_en[i]) begin
        if (cnt_q[i] == term) begin
          cnt_d[i]  = CNT_ZERO;
          slow_d[i] = ~slow_q[i];
          stb_d[i]  = 1'b1;
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // State registers with synchronous reset back to the default half-period.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= DEFAULT_HALF;
        cnt_q[i]  <= CNT_ZERO;
      end
      slow_q <= '0;
      stb_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      slow_q <= slow_d;
      stb_q  <= stb_d;
    end
  end

  assign slowclk    = slow_q;
  assign toggle_stb = stb_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_half_rd
    assign half_rd[g*CNT_W +: CNT_W] = half_q[g];
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios followed by random traffic,
// every cycle compared against a model that derives the outputs from the
// number of enabled cycles elapsed since the last phase restart.
module tb_prog_clk_divider;

  localparam int NCH = 3;
  localparam int CW  = 32;
  localparam int DEF = 4;

  logic              fastclk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_ch = 3'd0;
  logic [CW-1:0]     cfg_half = '0;
  logic              sync_restart = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH-1:0]    slowclk;
  logic [NCH-1:0]    toggle_stb;
  logic [NCH*CW-1:0] half_rd;

  int checks = 0;
  int errors = 0;

  // Reference model state: half-period and enabled-cycle count since restart.
  longint        el_m   [NCH];
  logic [CW-1:0] half_m [NCH];
  bit            stb_m  [NCH];

  prog_clk_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(CW'(DEF))) dut (
    .fastclk(fastclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .sync_restart(sync_restart), .ch_en(ch_en),
    .slowclk(slowclk), .toggle_stb(toggle_stb), .half_rd(half_rd)
  );

  always #5 fastclk = ~fastclk;

  function automatic longint eh_of(input logic [CW-1:0] h);
    return (h == '0) ? 64'd1 : longint'(h);
  endfunction

  // Advance the model by one posedge using the currently driven inputs.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit sel;
      sel = cfg_we && (int'(cfg_ch) == i);
      if (rst) begin
        half_m[i] = CW'(DEF);
        el_m[i]   = 0;
        stb_m[i]  = 1'b0;
      end else begin
        if (sel) half_m[i] = cfg_half;
        if (sync_restart || sel) begin
          el_m[i]  = 0;
          stb_m[i] = 1'b0;
        end else if (ch_en[i]) begin
          el_m[i]  = el_m[i] + 1;
          stb_m[i] = ((el_m[i] % eh_of(half_m[i])) == 0);
        end else begin
          stb_m[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NCH; i++) begin
      logic          exp_slow;
      logic          exp_stb;
      logic [CW-1:0] exp_half;
      exp_slow = logic'(((el_m[i] / eh_of(half_m[i])) % 2) == 1);
      exp_stb  = stb_m[i];
      exp_half = half_m[i];
      checks++;
      assert (slowclk[i] === exp_slow) else begin
        errors++;
        $error("FAIL slowclk[%0d] t=%0t observed %b expected %b", i, $time, slowclk[i], exp_slow);
      end
      checks++;
      assert (toggle_stb[i] === exp_stb) else begin
        errors++;
        $error("FAIL toggle_stb[%0d] t=%0t observed %b expected %b", i, $time, toggle_stb[i], exp_stb);
      end
      checks++;
      assert (half_rd[i*CW +: CW] === exp_half) else begin
        errors++;
        $error("FAIL half_rd[%0d] t=%0t observed %0d expected %0d", i, $time, half_rd[i*CW +: CW], exp_half);
      end
    end
  endtask

  // One clock: let the edge happen, update the model, compare 1 time unit later.
  task automatic tick();
    @(posedge fastclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [CW-1:0] h);
    cfg_we = 1'b1; cfg_ch = ch; cfg_half = h;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      el_m[i] = 0; half_m[i] = '0; stb_m[i] = 1'b0;
    end

    // Reset state.
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ch_en = 3'b111;

    // Default division: ch0 rises at edge 4, falls at edge 8.
    ticks(10);

    // Channel 1 at half=1 toggles every cycle.
    cfg_write(3'd1, 32'd1);
    ticks(6);

    // Pause channel 0 at count 2 for ten cycles, then resume.
    for (int k = 0; k < 8 && (el_m[0] % eh_of(half_m[0])) != 2; k++) tick();
    ch_en[0] = 1'b0;
    ticks(10);
    ch_en[0] = 1'b1;
    ticks(6);

    // Write ch2 half=6 exactly when its count is 3: write wins.
    for (int k = 0; k < 8 && (el_m[2] % eh_of(half_m[2])) != 3; k++) tick();
    cfg_write(3'd2, 32'd6);
    ticks(14);

    // sync_restart with an ignored out-of-range write.
    ticks(3);
    sync_restart = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd5; cfg_half = 32'd9;
    tick();
    sync_restart = 1'b0; cfg_we = 1'b0;
    ticks(14);

    // Half of zero behaves as one; reset mid-count restores defaults.
    cfg_write(3'd0, 32'd0);
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(6);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cfg_we       = ($urandom_range(0, 9) == 0);
      cfg_ch       = 3'($urandom_range(0, 7));
      cfg_half     = CW'($urandom_range(0, 7));
      sync_restart = ($urandom_range(0, 29) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0) ch_en = NCH'($urandom);
      tick();
    end
    cfg_we = 1'b0; sync_restart = 1'b0; rst = 1'b0;
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
